// File: rtl/pulse_cdc_sched_if.sv
// Handshake bundle between the event sources, the pulse CDC channel and the scheduler.
// The slave modport is the scheduler's view, and the master modport is the environment's view.
interface pulse_cdc_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req_pulse;
  logic               clr_status;
  logic               chan_busy;
  logic               chan_pulse;
  logic [ID_W-1:0]    chan_id;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] overflow;
  logic               timeout;
  logic               sched_busy;

  modport master (
    output req_pulse, clr_status, chan_busy,
    input  chan_pulse, chan_id, pending, overflow, timeout, sched_busy
  );

  modport slave (
    input  req_pulse, clr_status, chan_busy,
    output chan_pulse, chan_id, pending, overflow, timeout, sched_busy
  );
endinterface

// File: rtl/pulse_cdc_sched.sv
// Round-robin scheduler that shares one pulse CDC channel between NUM_REQ same-domain event sources.
// Defining PULSE_CDC_SCHED_TIMEOUT_EN bounds the wait for chan_busy and adds a sticky timeout flag.
// state     | meaning
// IDLE      | free to grant a pending request when the channel is not busy
// WAIT_ACK  | pulse issued, waiting for chan_busy to rise
// WAIT_DONE | round trip in flight, waiting for chan_busy to fall
// GAP       | enforced idle cycles before the next issue
module pulse_cdc_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input logic              clk,
  input logic              reset,
  pulse_cdc_sched_if.slave bus
);
  localparam int TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] pending_q, overflow_q, grant_clr;
  logic [ID_W-1:0]    ptr_q, ptr_nxt, grant_id, chan_id_q, idx;
  logic [ID_W:0]      sum;
  logic [TMR_W-1:0]   tmr_q, tmr_nxt;
  logic               grant_vld, issue, chan_pulse_q, sched_busy_q;
`ifdef PULSE_CDC_SCHED_TIMEOUT_EN
  logic               tmo_evt, timeout_q;
`endif

  // First pending bit at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!grant_vld && pending_q[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign issue   = (state == IDLE) && grant_vld && !bus.chan_busy;
  assign ptr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    grant_clr = '0;
    if (issue) grant_clr[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr_q;
`ifdef PULSE_CDC_SCHED_TIMEOUT_EN
    tmo_evt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = WAIT_ACK;
`ifdef PULSE_CDC_SCHED_TIMEOUT_EN
          tmr_nxt   = TMR_W'(TIMEOUT_CYCLES);
`endif
        end
      end
      WAIT_ACK: begin
        if (bus.chan_busy) state_nxt = WAIT_DONE;
`ifdef PULSE_CDC_SCHED_TIMEOUT_EN
        else if (tmr_q <= TMR_W'(1)) begin
          tmo_evt   = 1'b1;
          tmr_nxt   = TMR_W'(GAP_CYCLES);
          state_nxt = GAP;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.chan_busy) begin
          tmr_nxt   = TMR_W'(GAP_CYCLES);
          state_nxt = GAP;
        end
      end
      GAP: begin
        tmr_nxt = tmr_q - 1'b1;
        if (tmr_q <= TMR_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A request colliding with its own grant re-arms the pending bit and is not an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q        <= '0;
      pending_q    <= '0;
      overflow_q   <= '0;
      ptr_q        <= '0;
      chan_id_q    <= '0;
      chan_pulse_q <= 1'b0;
      sched_busy_q <= 1'b0;
    end else begin
      tmr_q        <= tmr_nxt;
      pending_q    <= (pending_q & ~grant_clr) | bus.req_pulse;
      overflow_q   <= (bus.clr_status ? '0 : overflow_q) | (bus.req_pulse & pending_q & ~grant_clr);
      chan_pulse_q <= issue;
      sched_busy_q <= (state_nxt != IDLE);
      if (issue) begin
        chan_id_q <= grant_id;
        ptr_q     <= ptr_nxt;
      end
    end
  end

`ifdef PULSE_CDC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= (timeout_q & ~bus.clr_status) | tmo_evt;
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.chan_pulse = chan_pulse_q;
  assign bus.chan_id    = chan_id_q;
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;
  assign bus.sched_busy = sched_busy_q;
endmodule

// File: tb/tb_pulse_cdc_sched.sv
// Directed bench for pulse_cdc_sched: a cycle-level behavioural model is compared every cycle,
// and hand-computed literal checks pin the scenarios (timeout scenario only with PULSE_CDC_SCHED_TIMEOUT_EN).
module tb_pulse_cdc_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int GAP     = 4;
  localparam int TMO     = 32;

  logic clk;
  logic reset;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  pulse_cdc_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  pulse_cdc_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Channel: busy for ch_len cycles starting ch_dly cycles after a pulse; ch_hold forces busy.
  bit ch_hold    = 1'b0;
  bit ch_en      = 1'b1;
  int ch_dly     = 3;
  int ch_len     = 5;
  int busy_start = -100;
  always @(posedge clk) begin
    #2;
    if (ch_en && bus.chan_pulse === 1'b1) busy_start = cyc + ch_dly;
    bus.chan_busy = ch_hold || (cyc >= busy_start && cyc < busy_start + ch_len);
  end

  int pq_cyc[$];
  int pq_id[$];
  always @(negedge clk)
    if (!reset && bus.chan_pulse === 1'b1) begin
      pq_cyc.push_back(cyc);
      pq_id.push_back(int'(bus.chan_id));
    end

  // Behavioural model: outstanding transfer ends GAP+1 cycles after busy is seen low again.
  logic [NUM_REQ-1:0] m_pend, m_ovf, gm, ev;
  logic [ID_W-1:0]    m_id;
  bit m_tmo, m_pulse, m_out, m_acked, m_valid, tev;
  int m_ptr, m_wait, m_rel, g, j;
  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_ovf = '0; m_tmo = 1'b0; m_pulse = 1'b0; m_id = '0;
      m_ptr = 0; m_out = 1'b0; m_acked = 1'b0; m_wait = 0; m_rel = -1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      g = -1;
      if (!m_out && m_pend != '0 && !bus.chan_busy)
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (m_ptr + k) % NUM_REQ;
          if (g < 0 && ((m_pend >> j) & 1) != 0) g = j;
        end
      gm  = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
      ev  = bus.req_pulse & m_pend & ~gm;
      tev = 1'b0;
      if (g >= 0) begin
        m_id = ID_W'(g); m_ptr = (g + 1) % NUM_REQ;
        m_out = 1'b1; m_acked = 1'b0; m_wait = 0; m_rel = -1;
      end else if (m_out && m_rel < 0) begin
        if (!m_acked) begin
          if (bus.chan_busy) m_acked = 1'b1;
`ifdef PULSE_CDC_SCHED_TIMEOUT_EN
          else begin
            m_wait++;
            if (m_wait == TMO) begin
              tev   = 1'b1;
              m_rel = cyc + GAP + 1;
            end
          end
`endif
        end else if (!bus.chan_busy) m_rel = cyc + GAP + 1;
      end
      m_pend  = (m_pend & ~gm) | bus.req_pulse;
      m_ovf   = (bus.clr_status ? '0 : m_ovf) | ev;
      m_tmo   = (bus.clr_status ? 1'b0 : m_tmo) | tev;
      m_pulse = (g >= 0);
      if (m_out && m_rel == cyc + 1) m_out = 1'b0;
    end
  end

  always @(negedge clk)
    if (m_valid) begin
      chk("cmp_pulse",    32'(bus.chan_pulse), 32'(m_pulse));
      chk("cmp_id",       32'(bus.chan_id),    32'(m_id));
      chk("cmp_pending",  32'(bus.pending),    32'(m_pend));
      chk("cmp_overflow", 32'(bus.overflow),   32'(m_ovf));
      chk("cmp_timeout",  32'(bus.timeout),    32'(m_tmo));
      chk("cmp_busy",     32'(bus.sched_busy), 32'(m_out));
    end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    pq_cyc.delete();
    pq_id.delete();
  endtask

  task automatic pulse_req(input logic [NUM_REQ-1:0] r);
    bus.req_pulse = r;
    step();
    bus.req_pulse = '0;
  endtask

  task automatic chk_pq(input string nm, input int i, input int exp_cyc, input int exp_id);
    chk({nm, "_cyc"}, (i < pq_cyc.size()) ? pq_cyc[i] : -1, exp_cyc);
    chk({nm, "_id"},  (i < pq_id.size())  ? pq_id[i]  : -1, exp_id);
  endtask

  int t0;
  initial begin
    reset = 1'b1;
    bus.req_pulse  = '0;
    bus.clr_status = 1'b0;

    // Reset state and single request latency
    do_reset();
    chk("rst_busy", 32'(bus.sched_busy), 0);
    chk("rst_pend", 32'(bus.pending), 0);
    t0 = cyc;
    pulse_req(4'b0100);
    chk("t1_pend", 32'(bus.pending), 32'h4);
    step();
    chk("t1_pulse", 32'(bus.chan_pulse), 1);
    chk("t1_id", 32'(bus.chan_id), 2);
    step(12);
    chk("t1_busy_hi", 32'(bus.sched_busy), 1);
    step();
    chk("t1_busy_lo", 32'(bus.sched_busy), 0);
    step(5);

    // All four at once: round-robin order with 14-cycle spacing
    do_reset();
    t0 = cyc;
    pulse_req(4'b1111);
    step(50);
    chk("t2_count", pq_cyc.size(), 4);
    for (int i = 0; i < 4; i++) chk_pq("t2_issue", i, t0 + 2 + 14 * i, i);
    chk("t2_ovf", 32'(bus.overflow), 0);

    // Coalesced requests, set beats clear, single issue of ID 1
    do_reset();
    t0 = cyc;
    pulse_req(4'b0001);
    step(3);
    pulse_req(4'b0010);
    chk("t3_pend", 32'(bus.pending), 32'h2);
    step();
    pulse_req(4'b0010);
    chk("t3_ovf_set", 32'(bus.overflow), 32'h2);
    bus.clr_status = 1'b1;
    pulse_req(4'b0010);
    bus.clr_status = 1'b0;
    chk("t3_set_wins", 32'(bus.overflow), 32'h2);
    bus.clr_status = 1'b1;
    step();
    bus.clr_status = 1'b0;
    chk("t3_ovf_clr", 32'(bus.overflow), 0);
    step(25);
    chk("t3_count", pq_cyc.size(), 2);
    chk_pq("t3_first", 0, t0 + 2, 0);
    chk_pq("t3_second", 1, t0 + 16, 1);

    // Request in the same cycle as its own grant
    do_reset();
    t0 = cyc;
    pulse_req(4'b1000);
    pulse_req(4'b1000);
    chk("t4_pulse", 32'(bus.chan_pulse), 1);
    chk("t4_id", 32'(bus.chan_id), 3);
    chk("t4_pend", 32'(bus.pending), 32'h8);
    chk("t4_ovf", 32'(bus.overflow), 0);
    step(20);
    chk("t4_count", pq_cyc.size(), 2);
    chk_pq("t4_second", 1, t0 + 16, 3);

    // Channel busy from reset blocks issue until it drops
    ch_hold = 1'b1;
    do_reset();
    t0 = cyc;
    pulse_req(4'b0001);
    step(9);
    chk("t5_none", pq_cyc.size(), 0);
    chk("t5_pend", 32'(bus.pending), 32'h1);
    chk("t5_idle", 32'(bus.sched_busy), 0);
    ch_hold = 1'b0;
    step();
    chk("t5_wait", 32'(bus.chan_pulse), 0);
    step();
    chk("t5_pulse", 32'(bus.chan_pulse), 1);
    chk("t5_id", 32'(bus.chan_id), 0);
    step(20);

    // Reset while the round trip is in flight
    do_reset();
    t0 = cyc;
    pulse_req(4'b0100);
    step(2);
    pulse_req(4'b0010);
    pulse_req(4'b0010);
    chk("t6_ovf", 32'(bus.overflow), 32'h2);
    chk("t6_id", 32'(bus.chan_id), 2);
    step();
    reset = 1'b1;
    step();
    chk("t6_rst_id", 32'(bus.chan_id), 0);
    chk("t6_rst_pend", 32'(bus.pending), 0);
    chk("t6_rst_ovf", 32'(bus.overflow), 0);
    chk("t6_rst_busy", 32'(bus.sched_busy), 0);
    chk("t6_rst_pulse", 32'(bus.chan_pulse), 0);
    reset = 1'b0;
    step(10);

`ifdef PULSE_CDC_SCHED_TIMEOUT_EN
    // Channel never acknowledges: timeout, gap, then the next pending request
    ch_en = 1'b0;
    do_reset();
    t0 = cyc;
    pulse_req(4'b0011);
    step(32);
    chk("t7_tmo_lo", 32'(bus.timeout), 0);
    step();
    chk("t7_tmo_hi", 32'(bus.timeout), 1);
    step(3);
    chk("t7_gap", 32'(bus.sched_busy), 1);
    step();
    chk("t7_idle", 32'(bus.sched_busy), 0);
    step();
    chk("t7_next", 32'(bus.chan_pulse), 1);
    chk("t7_next_id", 32'(bus.chan_id), 1);
    bus.clr_status = 1'b1;
    step();
    bus.clr_status = 1'b0;
    chk("t7_tmo_clr", 32'(bus.timeout), 0);
    step(45);
    ch_en = 1'b1;
`endif

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
